// File: rtl/sha1_mem_block_fetcher_pkg.sv
// Shared types and constants for the SHA-1 message RAM block fetcher.
// SHA1_FETCH_BSWAP_EN selects the byte-swap helper use in the top.
package sha1_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_FETCH    = 3'd2,
    S_DRAIN    = 3'd3,
    S_WAIT_DIG = 3'd4,
    S_WRITE    = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int DIGEST_WORDS    = 5;
  localparam logic [3:0] BE_ALL  = 4'hF;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha1_mem_block_fetcher_if.sv
// RAM port, message-word stream and digest handshake of the fetcher.
// Handshake: a word (or digest) transfers on a cycle where valid && ready;
// the sender holds data stable while valid && !ready.
interface sha1_mem_block_fetcher_if #(parameter int MEM_AW = 13);
  logic [MEM_AW-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic [31:0]       w_data;
  logic              w_valid;
  logic              w_ready;
  logic              w_eob;
  logic              w_last;
  logic              dig_valid;
  logic [159:0]      dig_data;
  logic              dig_ready;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata,
    output w_data, w_valid, w_eob, w_last, dig_ready,
    input  mem_readdata, w_ready, dig_valid, dig_data
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata,
    input  w_data, w_valid, w_eob, w_last, dig_ready,
    output mem_readdata, w_ready, dig_valid, dig_data
  );
endinterface

// File: rtl/sha1_mem_block_fetcher_fifo.sv
// Two-entry register FIFO buffering RAM read data ahead of the word stream.
module sha1_fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count,
  output logic         o_valid
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
endmodule

// File: rtl/sha1_mem_block_fetcher.sv
// Streams num_blocks x 16 RAM words to the SHA-1 core, then writes the digest back.
// Define SHA1_FETCH_BSWAP_EN to byte-swap stream words and digest words.
module sha1_mem_block_fetcher
  import sha1_mem_pkg::*;
#(
  parameter int MEM_AW    = 13,
  parameter int MEM_WORDS = 7500,
  parameter int NBLK_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MEM_AW-1:0] base_addr,
  input  logic [MEM_AW-1:0] dst_addr,
  input  logic [NBLK_W-1:0] num_blocks,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            o_dbg_state,
  sha1_mem_block_fetcher_if.master bus
);
  localparam int SUM_W = MEM_AW + NBLK_W + 5;
  localparam int CNT_W = NBLK_W + 4;

  state_t            r_state, w_next;
  logic [MEM_AW-1:0] r_base, r_dst, r_rd_addr;
  logic [NBLK_W-1:0] r_nblk;
  logic              r_err, r_inflight;
  logic [CNT_W-1:0]  r_rd_cnt, r_out_cnt;
  logic [159:0]      r_dig;
  logic [2:0]        r_wr_idx;

  logic [CNT_W-1:0]  w_total;
  logic [SUM_W-1:0]  w_src_end, w_dst_end;
  logic              w_range_bad, w_issue, w_pop, w_fifo_valid;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_occ;
  logic [31:0]       w_fifo_data, w_dig_word;
  logic [MEM_AW-1:0] w_addr;
  logic              w_cs, w_we;

  assign w_total     = {r_nblk, 4'b0000};
  assign w_src_end   = SUM_W'(r_base) + (SUM_W'(r_nblk) << 4);
  assign w_dst_end   = SUM_W'(r_dst) + SUM_W'(DIGEST_WORDS);
  assign w_range_bad = (w_src_end > SUM_W'(MEM_WORDS)) || (w_dst_end > SUM_W'(MEM_WORDS));

  assign w_pop = w_fifo_valid && bus.w_ready;
  // Occupancy after this cycle's dequeue plus the read in flight; a new read keeps it <= 2.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_FETCH) && (w_occ < 3'd2);

  sha1_fetch_fifo #(.W(32)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (r_inflight),
    .i_data  (bus.mem_readdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_valid (w_fifo_valid)
  );

  always_comb begin
    w_dig_word = 32'h0;
    case (r_wr_idx)
      3'd0:    w_dig_word = r_dig[159:128];
      3'd1:    w_dig_word = r_dig[127:96];
      3'd2:    w_dig_word = r_dig[95:64];
      3'd3:    w_dig_word = r_dig[63:32];
      3'd4:    w_dig_word = r_dig[31:0];
      default: w_dig_word = 32'h0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_cs          = 1'b0;
    w_we          = 1'b0;
    w_addr        = '0;
    bus.dig_ready = 1'b0;
    done          = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: begin
        if (r_nblk == '0 || w_range_bad) w_next = S_FIN;
        else                             w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_issue) begin
          w_cs   = 1'b1;
          w_addr = r_rd_addr;
          if (r_rd_cnt == w_total - CNT_W'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: if (w_fifo_count == 2'd0 && !r_inflight) w_next = S_WAIT_DIG;
      S_WAIT_DIG: begin
        bus.dig_ready = 1'b1;
        if (bus.dig_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_cs   = 1'b1;
        w_we   = 1'b1;
        w_addr = r_dst + MEM_AW'(r_wr_idx);
        if (r_wr_idx == 3'(DIGEST_WORDS - 1)) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base     <= '0;
      r_dst      <= '0;
      r_nblk     <= '0;
      r_err      <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
      r_dig      <= '0;
      r_wr_idx   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == S_IDLE && start) begin
        r_base    <= base_addr;
        r_dst     <= dst_addr;
        r_nblk    <= num_blocks;
        r_err     <= 1'b0;
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
        r_wr_idx  <= '0;
      end
      if (r_state == S_CHECK) begin
        r_rd_addr <= r_base;
        r_err     <= (r_nblk != '0) && w_range_bad;
      end
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + MEM_AW'(1);
        r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
      end
      if (w_pop) r_out_cnt <= r_out_cnt + CNT_W'(1);
      if (r_state == S_WAIT_DIG && bus.dig_valid) r_dig <= bus.dig_data;
      if (r_state == S_WRITE) r_wr_idx <= r_wr_idx + 3'd1;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign o_dbg_state = r_state;

  assign bus.mem_chipselect = w_cs;
  assign bus.mem_write      = w_we;
  assign bus.mem_address    = w_addr;
  assign bus.mem_byteenable = w_cs ? BE_ALL : 4'h0;
  assign bus.w_valid        = w_fifo_valid;
  assign bus.w_eob          = w_fifo_valid && (r_out_cnt[3:0] == 4'hF);
  assign bus.w_last         = w_fifo_valid && (r_out_cnt == w_total - CNT_W'(1));
`ifdef SHA1_FETCH_BSWAP_EN
  assign bus.w_data         = bswap32(w_fifo_data);
  assign bus.mem_writedata  = w_we ? bswap32(w_dig_word) : 32'h0;
`else
  assign bus.w_data         = w_fifo_data;
  assign bus.mem_writedata  = w_we ? w_dig_word : 32'h0;
`endif
endmodule

// File: tb/tb_sha1_mem_block_fetcher.sv
// Directed bench for sha1_mem_block_fetcher: RAM model, stream/digest drivers, monitor.
module tb_sha1_mem_block_fetcher;
  import sha1_mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [12:0] base_addr, dst_addr;
  logic [7:0]  num_blocks;
  logic        busy, done, err;
  state_t      dbg_state;

  sha1_mem_block_fetcher_if #(.MEM_AW(13)) bus ();

  sha1_mem_block_fetcher #(.MEM_AW(13), .MEM_WORDS(7500), .NBLK_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .dst_addr(dst_addr), .num_blocks(num_blocks), .busy(busy), .done(done),
    .err(err), .o_dbg_state(dbg_state), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sw32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] raw_word(input logic [12:0] a);
    if (a == 13'h100) return 32'h1122_3344;
    return {16'hBEEF, 3'b000, a};
  endfunction

  function automatic logic [31:0] exp_out(input logic [31:0] x);
`ifdef SHA1_FETCH_BSWAP_EN
    return sw32(x);
`else
    return x;
`endif
  endfunction

  // RAM model: q is valid the cycle after a read is issued.
  always @(posedge clk) begin
    if (bus.mem_chipselect && !bus.mem_write) bus.mem_readdata <= raw_word(bus.mem_address);
    else                                      bus.mem_readdata <= 32'hDEAD_DEAD;
  end

  logic rdy_toggle, rdy_level;
  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) bus.w_ready = ~bus.w_ready;
      else            bus.w_ready = rdy_level;
    end
  end

  // Monitor: logs bus activity at the falling edge.
  logic        mon_clr;
  logic [12:0] rd_q[$];
  logic [12:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  logic [33:0] st_q[$];
  int cyc, issued, accepted, max_out, done_cnt, dig_rdy_cnt, stall_viol, first_acc, last_acc;
  logic        prev_stall;
  logic [33:0] prev_word;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_clr) begin
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete(); st_q.delete();
      issued = 0; accepted = 0; max_out = 0; done_cnt = 0; dig_rdy_cnt = 0;
      stall_viol = 0; first_acc = 0; last_acc = 0; prev_stall = 1'b0;
    end else if (reset_n) begin
      if (prev_stall && (!bus.w_valid || {bus.w_last, bus.w_eob, bus.w_data} !== prev_word))
        stall_viol = stall_viol + 1;
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_word  = {bus.w_last, bus.w_eob, bus.w_data};
      if (bus.mem_chipselect && !bus.mem_write) begin
        rd_q.push_back(bus.mem_address);
        issued = issued + 1;
      end
      if (bus.mem_chipselect && bus.mem_write) begin
        wr_a_q.push_back(bus.mem_address);
        wr_d_q.push_back(bus.mem_writedata);
      end
      if (bus.w_valid && bus.w_ready) begin
        if (accepted == 0) first_acc = cyc;
        last_acc = cyc;
        st_q.push_back({bus.w_last, bus.w_eob, bus.w_data});
        accepted = accepted + 1;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (done) done_cnt = done_cnt + 1;
      if (bus.dig_ready) dig_rdy_cnt = dig_rdy_cnt + 1;
    end
  end

  int n_pass, n_total, n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic go(input logic [12:0] b, input logic [12:0] d, input logic [7:0] n);
    @(posedge clk); #1;
    base_addr = b; dst_addr = d; num_blocks = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 13'h1FFF; dst_addr = 13'h1FFF; num_blocks = 8'hFF;
  endtask

  task automatic serve_digest(input string tag, input logic [159:0] d);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.dig_ready && n < 2000);
    check({tag, "_dig_ready_seen"}, 64'(bus.dig_ready), 64'(1));
    if (bus.dig_ready) begin
      bus.dig_valid = 1'b1; bus.dig_data = d;
      @(posedge clk); #1;
      bus.dig_valid = 1'b0; bus.dig_data = '0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin @(negedge clk); cycles++; end while (!done && cycles < budget);
    check({tag, "_done_seen"}, 64'(done), 64'(1));
  endtask

  function automatic logic [159:0] mk_dig(input logic [31:0] seed);
    return {seed, seed + 32'd1, seed + 32'd2, seed + 32'd3, seed + 32'd4};
  endfunction

  task automatic check_run(input string tag, input logic [12:0] b, input logic [12:0] d,
                           input int nw, input logic [31:0] seed);
    check({tag, "_rd_count"}, 64'(rd_q.size()), 64'(nw));
    check({tag, "_st_count"}, 64'(st_q.size()), 64'(nw));
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s_rd%0d", tag, i), 64'(rd_q[i]), 64'(32'(b) + i));
      check($sformatf("%s_w%0d", tag, i), 64'(st_q[i]),
            64'({(i == nw - 1), (i % 16 == 15), exp_out(raw_word(13'(32'(b) + i)))}));
    end
    check({tag, "_wr_count"}, 64'(wr_a_q.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_wa%0d", tag, k), 64'(wr_a_q[k]), 64'(32'(d) + k));
      check($sformatf("%s_wd%0d", tag, k), 64'(wr_d_q[k]), 64'(exp_out(seed + 32'(k))));
    end
    check({tag, "_stall_stable"}, 64'(stall_viol), 64'(0));
    check({tag, "_outstanding_le2"}, 64'(max_out <= 2), 64'(1));
  endtask

  initial begin
    int cy;
    n_pass = 0; n_total = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; dst_addr = '0; num_blocks = '0;
    bus.dig_valid = 1'b0; bus.dig_data = '0;
    rdy_toggle = 1'b0; rdy_level = 1'b1; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_cs", 64'(bus.mem_chipselect), 64'(0));
    check("rst_be", 64'(bus.mem_byteenable), 64'(0));
    check("rst_wvalid", 64'(bus.w_valid), 64'(0));
    check("rst_digrdy", 64'(bus.dig_ready), 64'(0));
    reset_n = 1'b1;
    mon_clear();

    // Single block, full-rate consumer.
    go(13'h100, 13'h1000, 8'd1);
    serve_digest("t1", mk_dig(32'hA5A5_0000));
    wait_done("t1", 100, cy);
    check("t1_err", 64'(err), 64'(0));
    @(posedge clk); #1;
    check("t1_busy_after", 64'(busy), 64'(0));
    check_run("t1", 13'h100, 13'h1000, 16, 32'hA5A5_0000);
    check("t1_throughput", 64'(last_acc - first_acc), 64'(15));
    check("t1_done_cnt", 64'(done_cnt), 64'(1));
    mon_clear();

    // Three blocks with a toggling consumer.
    rdy_toggle = 1'b1;
    go(13'h200, 13'h1100, 8'd3);
    serve_digest("t2", mk_dig(32'h1357_0000));
    rdy_toggle = 1'b0;
    wait_done("t2", 100, cy);
    check("t2_err", 64'(err), 64'(0));
    check_run("t2", 13'h200, 13'h1100, 48, 32'h1357_0000);
    mon_clear();

    // Message range past the end of RAM.
    go(13'd7490, 13'h0, 8'd1);
    wait_done("t3", 10, cy);
    check("t3_fast_done", 64'(cy <= 3), 64'(1));
    check("t3_err", 64'(err), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("t3_err_hold", 64'(err), 64'(1));
    check("t3_no_ram", 64'(rd_q.size() + wr_a_q.size()), 64'(0));
    mon_clear();

    // Digest range one past the end of RAM.
    go(13'h0, 13'd7496, 8'd1);
    wait_done("t3b", 10, cy);
    check("t3b_err", 64'(err), 64'(1));
    check("t3b_no_ram", 64'(rd_q.size()), 64'(0));
    mon_clear();

    // Both ranges ending exactly at the last legal word.
    go(13'd7484, 13'd7495, 8'd1);
    serve_digest("t3c", mk_dig(32'h0BAD_F00D));
    wait_done("t3c", 100, cy);
    check("t3c_err", 64'(err), 64'(0));
    check_run("t3c", 13'd7484, 13'd7495, 16, 32'h0BAD_F00D);
    mon_clear();

    // Zero blocks: completes with no RAM or digest activity.
    go(13'h40, 13'h80, 8'd0);
    wait_done("t4", 10, cy);
    check("t4_err", 64'(err), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("t4_no_ram", 64'(rd_q.size() + wr_a_q.size()), 64'(0));
    check("t4_no_dig", 64'(dig_rdy_cnt), 64'(0));
    mon_clear();

    // Reset during the fetch, then a clean run from word 0.
    go(13'h300, 13'h1200, 8'd1);
    cy = 0;
    while (accepted < 7 && cy < 100) begin @(negedge clk); cy++; end
    check("t5_reached_w7", 64'(accepted), 64'(7));
    #2 reset_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_state", 64'(dbg_state), 64'(S_IDLE));
    check("t5_cs", 64'(bus.mem_chipselect), 64'(0));
    check("t5_wvalid", 64'(bus.w_valid), 64'(0));
    check("t5_eob_last", 64'({bus.w_eob, bus.w_last}), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    check("t5_no_done", 64'(done_cnt), 64'(0));
    #1 reset_n = 1'b1;
    mon_clear();
    go(13'h0, 13'h1200, 8'd1);
    serve_digest("t5", mk_dig(32'hCAFE_0000));
    wait_done("t5", 100, cy);
    check_run("t5", 13'h0, 13'h1200, 16, 32'hCAFE_0000);
    mon_clear();

    // Start pulsed during WRITE is ignored.
    go(13'h400, 13'h1300, 8'd1);
    serve_digest("t6", mk_dig(32'h7777_0000));
    check("t6_in_write", 64'(dbg_state), 64'(S_WRITE));
    base_addr = 13'h500; dst_addr = 13'h1400; num_blocks = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6", 20, cy);
    repeat (10) @(posedge clk);
    #1;
    check("t6_idle", 64'(dbg_state), 64'(S_IDLE));
    check("t6_done_cnt", 64'(done_cnt), 64'(1));
    check_run("t6", 13'h400, 13'h1300, 16, 32'h7777_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
